// File: rtl/can_pkg.sv
// Shared CAN frame definitions used by the receive FIFO, can_rx and can_tx.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package can_pkg;

  localparam int CAN_ID_W   = 29;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;

  // Byte 0 of the payload lives in data[63:56].
  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic                  ide;
    logic                  rtr;
    logic [CAN_DLC_W-1:0]  dlc;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  localparam int FRAME_W = $bits(can_frame_t);

  // Classic CAN carries at most 8 bytes; DLC codes 9..15 all mean 8.
  function automatic logic [CAN_DLC_W-1:0] dlc_clamp(input logic [CAN_DLC_W-1:0] dlc);
    return (dlc > CAN_DLC_W'(8)) ? CAN_DLC_W'(8) : dlc;
  endfunction

endpackage

// File: rtl/can_rx_frame_fifo_if.sv
// Frame-in strobe bus from can_rx plus the first-word-fall-through read port.
// Wires only: no latency.
// Read side is valid/ready; the frame strobe side cannot be stalled.
interface can_rx_frame_fifo_if;
  import can_pkg::*;

  logic                  frm_valid_i;
  logic [CAN_ID_W-1:0]   frm_id_i;
  logic                  frm_ide_i;
  logic                  frm_rtr_i;
  logic [CAN_DLC_W-1:0]  frm_dlc_i;
  logic [CAN_DATA_W-1:0] frm_data_i;

  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [CAN_ID_W-1:0]   rd_id_o;
  logic                  rd_ide_o;
  logic                  rd_rtr_o;
  logic [CAN_DLC_W-1:0]  rd_dlc_o;
  logic [CAN_DATA_W-1:0] rd_data_o;

  // Producer of frames and consumer of the read port (receiver + host side).
  modport master (
    output frm_valid_i, frm_id_i, frm_ide_i, frm_rtr_i, frm_dlc_i, frm_data_i,
    output rd_ready_i,
    input  rd_valid_o, rd_id_o, rd_ide_o, rd_rtr_o, rd_dlc_o, rd_data_o
  );

  // The FIFO itself.
  modport slave (
    input  frm_valid_i, frm_id_i, frm_ide_i, frm_rtr_i, frm_dlc_i, frm_data_i,
    input  rd_ready_i,
    output rd_valid_o, rd_id_o, rd_ide_o, rd_rtr_o, rd_dlc_o, rd_data_o
  );

endinterface

// File: rtl/can_acceptance_filter.sv
// Acceptance filter hit test plus DLC clamp and payload byte zeroing.
// Purely combinational (0 cycles).
// No flow control; evaluated whenever inputs change.
module can_acceptance_filter
  import can_pkg::*;
(
  input  logic [CAN_ID_W-1:0]   id_i,
  input  logic                  ide_i,
  input  logic                  rtr_i,
  input  logic [CAN_DLC_W-1:0]  dlc_i,
  input  logic [CAN_DATA_W-1:0] data_i,
  input  logic [CAN_ID_W-1:0]   code_i,
  input  logic [CAN_ID_W-1:0]   mask_i,
  output logic                  hit_o,
  output can_frame_t            frame_o
);

  logic [CAN_ID_W-1:0]  mask_eff;
  logic [CAN_DLC_W-1:0] dlc_c;

  // Standard frames only own id[28:18], so the low mask bits are forced off.
  // The stored DLC is always clamped so the host never sees a code above 8;
  // remote frames keep that DLC but carry no payload.
  always_comb begin
    mask_eff = mask_i;
    if (!ide_i) begin
      mask_eff[17:0] = '0;
    end
    hit_o = ((id_i ^ code_i) & mask_eff) == '0;

    dlc_c        = dlc_clamp(dlc_i);
    frame_o.id   = id_i;
    frame_o.ide  = ide_i;
    frame_o.rtr  = rtr_i;
    frame_o.dlc  = dlc_c;
    frame_o.data = '0;
    if (!rtr_i) begin
      for (int b = 0; b < CAN_DATA_W / 8; b++) begin
        if (CAN_DLC_W'(b) < dlc_c) begin
          frame_o.data[CAN_DATA_W-1-8*b -: 8] = data_i[CAN_DATA_W-1-8*b -: 8];
        end
      end
    end
  end

endmodule

// File: rtl/can_rx_frame_fifo.sv
// Filters received CAN frames and buffers accepted ones for the host (FWFT read).
// Latency: strobe at cycle N is visible on rd_* at N+2 (filter stage + commit).
// Read side valid/ready; input cannot stall, so hits arriving while full are counted as drops.
module can_rx_frame_fifo
  import can_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  can_rx_frame_fifo_if.slave      bus,
  input  logic [CAN_ID_W-1:0]     acc_code_i,
  input  logic [CAN_ID_W-1:0]     acc_mask_i,
  input  logic                    drop_clr_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic [CNT_W-1:0]        drop_cnt_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(DEPTH);

  logic                flt_hit;
  can_frame_t          flt_frm;

  logic                st1_vld_q, st1_vld_d;
  logic                st1_hit_q, st1_hit_d;
  can_frame_t          st1_frm_q, st1_frm_d;

  can_frame_t          mem_q [DEPTH];
  can_frame_t          mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]   count_q, count_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                rd_vld, pop, full, push, drop;
  can_frame_t          head;

  can_acceptance_filter u_filter (
    .id_i   (bus.frm_id_i),
    .ide_i  (bus.frm_ide_i),
    .rtr_i  (bus.frm_rtr_i),
    .dlc_i  (bus.frm_dlc_i),
    .data_i (bus.frm_data_i),
    .code_i (acc_code_i),
    .mask_i (acc_mask_i),
    .hit_o  (flt_hit),
    .frame_o(flt_frm)
  );

  // Stage 1: capture the filtered frame and its hit flag on every strobe.
  always_comb begin
    st1_vld_d = bus.frm_valid_i;
    st1_hit_d = st1_hit_q;
    st1_frm_d = st1_frm_q;
    if (bus.frm_valid_i) begin
      st1_hit_d = flt_hit;
      st1_frm_d = flt_frm;
    end
  end

  // Stage 2 commit, pointer/occupancy update and drop counting.
  // A same-cycle pop frees a slot, so a hit on a full FIFO still commits.
  always_comb begin
    rd_vld = (count_q != '0);
    pop    = rd_vld & bus.rd_ready_i;
    full   = (count_q == DEPTH_C);
    push   = st1_vld_q & st1_hit_q & (~full | pop);
    drop   = st1_vld_q & st1_hit_q & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = st1_frm_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_FW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_FW'(1);
    end

    drop_cnt_d = drop_cnt_q;
    if (drop_clr_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards the pending frame and all stored frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st1_vld_q  <= 1'b0;
      st1_hit_q  <= 1'b0;
      st1_frm_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      st1_vld_q  <= st1_vld_d;
      st1_hit_q  <= st1_hit_d;
      st1_frm_q  <= st1_frm_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head frame falls through; outputs read as zero whenever the FIFO is empty.
  always_comb begin
    head           = rd_vld ? mem_q[rd_ptr_q] : '0;
    bus.rd_valid_o = rd_vld;
    bus.rd_id_o    = head.id;
    bus.rd_ide_o   = head.ide;
    bus.rd_rtr_o   = head.rtr;
    bus.rd_dlc_o   = head.dlc;
    bus.rd_data_o  = head.data;
    count_o        = count_q;
    full_o         = full;
    drop_cnt_o     = drop_cnt_q;
  end

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Directed self-checking bench for can_rx_frame_fifo (DEPTH=4, CNT_W=8).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
// Every expected value below is hand-computed from the frame/filter definitions.
module tb_can_rx_frame_fifo;
  import can_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [CAN_ID_W-1:0]   acc_code;
  logic [CAN_ID_W-1:0]   acc_mask;
  logic                  drop_clr;
  logic [2:0]            count;
  logic                  full;
  logic [7:0]            drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  can_rx_frame_fifo_if bus ();

  can_rx_frame_fifo #(.DEPTH(4), .CNT_W(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .acc_code_i(acc_code),
    .acc_mask_i(acc_mask),
    .drop_clr_i(drop_clr),
    .count_o   (count),
    .full_o    (full),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns one cycle later (frame now in stage 1).
  task automatic send(input logic [28:0] id, input logic ide, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] data);
    bus.frm_id_i    = id;
    bus.frm_ide_i   = ide;
    bus.frm_rtr_i   = rtr;
    bus.frm_dlc_i   = dlc;
    bus.frm_data_i  = data;
    bus.frm_valid_i = 1'b1;
    tick();
    bus.frm_valid_i = 1'b0;
  endtask

  task automatic pop();
    bus.rd_ready_i = 1'b1;
    tick();
    bus.rd_ready_i = 1'b0;
  endtask

  logic [28:0] exp_ids [4];

  initial begin
    bus.frm_valid_i = 1'b0;
    bus.frm_id_i    = '0;
    bus.frm_ide_i   = 1'b0;
    bus.frm_rtr_i   = 1'b0;
    bus.frm_dlc_i   = '0;
    bus.frm_data_i  = '0;
    bus.rd_ready_i  = 1'b0;
    acc_code        = '0;
    acc_mask        = '0;
    drop_clr        = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", bus.rd_valid_o, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_drop", drop_cnt, 8'd0);
    chk("rst_id", bus.rd_id_o, 29'd0);
    chk("rst_data", bus.rd_data_o, 64'd0);

    // Single extended frame, mask 0 accepts all; visible two cycles after strobe
    send(29'h1ABCDE12, 1'b1, 1'b0, 4'd8, 64'h3132333435363738);
    chk("single_lat1_valid", bus.rd_valid_o, 1'b0);
    tick();
    chk("single_valid", bus.rd_valid_o, 1'b1);
    chk("single_id", bus.rd_id_o, 29'h1ABCDE12);
    chk("single_ide", bus.rd_ide_o, 1'b1);
    chk("single_rtr", bus.rd_rtr_o, 1'b0);
    chk("single_dlc", bus.rd_dlc_o, 4'd8);
    chk("single_data", bus.rd_data_o, 64'h3132333435363738);
    chk("single_count", count, 3'd1);
    tick();
    chk("single_stable_id", bus.rd_id_o, 29'h1ABCDE12);
    pop();
    chk("single_pop_count", count, 3'd0);
    chk("single_pop_valid", bus.rd_valid_o, 1'b0);
    pop();
    chk("empty_pop_count", count, 3'd0);

    // Filter: 0x155 matches code 0x100 under mask 0x1FFFFF00, 0x255 does not
    acc_code = 29'h0000_0100;
    acc_mask = 29'h1FFF_FF00;
    send(29'h0000_0155, 1'b1, 1'b0, 4'd1, 64'hAA00000000000000);
    send(29'h0000_0255, 1'b1, 1'b0, 4'd1, 64'hBB00000000000000);
    tick();
    tick();
    chk("filt_count", count, 3'd1);
    chk("filt_id", bus.rd_id_o, 29'h0000_0155);
    chk("filt_drop", drop_cnt, 8'd0);
    pop();

    // Standard frame: low 18 ID bits differ but are not compared
    acc_code = {11'h123, 18'h00000};
    acc_mask = 29'h1FFF_FFFF;
    send({11'h123, 18'h3FFFF}, 1'b0, 1'b0, 4'd0, 64'hFFFFFFFFFFFFFFFF);
    tick();
    chk("std_hit_count", count, 3'd1);
    chk("std_data_dlc0", bus.rd_data_o, 64'd0);
    // Filter setting changes do not touch a stored frame
    acc_code = 29'h1FFF_FFFF;
    tick();
    chk("std_stored_id", bus.rd_id_o, {11'h123, 18'h3FFFF});
    pop();

    // Overflow: five hits, fifth is dropped
    acc_code = '0;
    acc_mask = '0;
    for (int i = 0; i < 5; i++) begin
      send(29'h10 + 29'(i), 1'b1, 1'b0, 4'd2, 64'h1122000000000000);
    end
    tick();
    tick();
    chk("ovf_count", count, 3'd4);
    chk("ovf_full", full, 1'b1);
    chk("ovf_drop", drop_cnt, 8'd1);

    // drop_clr wins over an increment in the same cycle
    send(29'h77, 1'b1, 1'b0, 4'd0, 64'd0);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("clr_prio_drop", drop_cnt, 8'd0);

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) begin
      send(29'h88, 1'b1, 1'b0, 4'd0, 64'd0);
    end
    tick();
    tick();
    chk("sat_drop", drop_cnt, 8'hFF);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("clr_drop", drop_cnt, 8'd0);
    chk("sat_count", count, 3'd4);

    // Full FIFO: commit coincides with a pop -> no drop, count stays 4
    send(29'h66, 1'b1, 1'b0, 4'd0, 64'd0);
    chk("sim_head_id", bus.rd_id_o, 29'h10);
    pop();
    chk("sim_count", count, 3'd4);
    chk("sim_full", full, 1'b1);
    chk("sim_drop", drop_cnt, 8'd0);
    exp_ids[0] = 29'h11;
    exp_ids[1] = 29'h12;
    exp_ids[2] = 29'h13;
    exp_ids[3] = 29'h66;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order_id%0d", i), bus.rd_id_o, exp_ids[i]);
      pop();
    end
    chk("drain_count", count, 3'd0);
    chk("drain_valid", bus.rd_valid_o, 1'b0);
    chk("drain_data", bus.rd_data_o, 64'd0);

    // DLC clamp, byte zeroing, remote frame
    send(29'h21, 1'b0, 1'b0, 4'd13, 64'hFFFFFFFFFFFFFFFF);
    send(29'h22, 1'b0, 1'b0, 4'd3, 64'hFFFFFFFFFFFFFFFF);
    send(29'h23, 1'b0, 1'b1, 4'd4, 64'hFFFFFFFFFFFFFFFF);
    tick();
    chk("dlc_count", count, 3'd3);
    chk("dlc13_dlc", bus.rd_dlc_o, 4'd8);
    chk("dlc13_data", bus.rd_data_o, 64'hFFFFFFFFFFFFFFFF);
    pop();
    chk("dlc3_dlc", bus.rd_dlc_o, 4'd3);
    chk("dlc3_data", bus.rd_data_o, 64'hFFFFFF0000000000);
    pop();
    chk("rtr_flag", bus.rd_rtr_o, 1'b1);
    chk("rtr_dlc", bus.rd_dlc_o, 4'd4);
    chk("rtr_data", bus.rd_data_o, 64'd0);
    pop();

    // Reset mid-stream discards stored and pending frames
    send(29'h31, 1'b1, 1'b0, 4'd1, 64'h5500000000000000);
    tick();
    chk("pre_rst_count", count, 3'd1);
    send(29'h32, 1'b1, 1'b0, 4'd1, 64'h6600000000000000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", count, 3'd0);
    tick();
    tick();
    chk("post_rst_valid", bus.rd_valid_o, 1'b0);
    chk("post_rst_count", count, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
